// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store stage.
// A grant FSM issues registered requests and returns one-cycle completion pulses.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int ADDR_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    input  logic [3:0]        dm_wstrb,
    output logic [31:0]       dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] streak;
    logic       kill;
    logic       arb;
    logic       if_elig;
    logic       dm_elig;
    logic       grant_if;
    logic       grant_dm;
    logic       fetch_done;
    logic       fetch_ok;
    logic       data_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A requester whose transaction is completing or whose valid pulse is
    // showing still holds req high for that request, so it is not a candidate.
    always_comb begin
        fetch_done = (state == FETCH) && mem_ready;
        data_done  = (state == DATA) && mem_ready;
        fetch_ok   = fetch_done && !kill && !flush;
        arb        = (state == IDLE) || fetch_done || data_done;
        if_elig    = if_req && !if_valid && (state != FETCH);
        dm_elig    = dm_req && !dm_valid && (state != DATA);
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        state_nxt  = state;
        if (arb) begin
            if (if_elig && dm_elig) begin
                if (streak == STREAK_MAX) grant_if = 1'b1;
                else                      grant_dm = 1'b1;
            end else begin
                grant_if = if_elig;
                grant_dm = dm_elig;
            end
            if (grant_if)      state_nxt = FETCH;
            else if (grant_dm) state_nxt = DATA;
            else               state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
            kill   <= 1'b0;
        end else begin
            if (grant_if || !if_req)
                streak <= '0;
            else if (grant_dm && streak != STREAK_MAX)
                streak <= streak + 4'd1;
            // A redirect orphans the outstanding fetch; memory still finishes it.
            if (state == FETCH) begin
                if (mem_ready)  kill <= 1'b0;
                else if (flush) kill <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (arb) begin
            mem_req <= grant_if || grant_dm;
            if (grant_if) begin
                mem_addr  <= if_addr;
                mem_we    <= 1'b0;
                mem_wdata <= '0;
                mem_wstrb <= '0;
            end else if (grant_dm) begin
                mem_addr  <= dm_addr;
                mem_we    <= dm_we;
                mem_wdata <= dm_we ? dm_wdata : '0;
                mem_wstrb <= dm_we ? dm_wstrb : 4'b0000;
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if_valid <= fetch_ok;
            dm_valid <= data_done;
            if (fetch_ok)              if_rdata <= mem_rdata;
            if (data_done && !mem_we)  dm_rdata <= mem_rdata;
        end
    end

    assign if_stall = if_req && !if_valid;
    assign dm_stall = dm_req && !dm_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic,
// all cycles compared against a transaction-ownership reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        flush = 1'b0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_wstrb = '0;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_DATA_STREAK(MAXS), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .flush(flush),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who currently owns the port and what it asked for.
    int          owner;          // 0 nobody, 1 fetch, 2 data
    int          streak;
    bit          killed;
    bit          exp_ifv;
    bit          exp_dmv;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic        x_we;
    logic [3:0]  x_wstrb;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;
    bit          seen_ifv;
    bit          seen_dmv;
    int          st_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = 0; streak = 0; killed = 0; exp_ifv = 0; exp_dmv = 0;
        x_addr = '0; x_wdata = '0; x_we = 0; x_wstrb = '0;
        exp_if_rdata = '0; exp_dm_rdata = '0;
    endtask

    task automatic cycle_checks();
        chk("mem_req", 32'(mem_req), 32'(owner != 0));
        if (owner != 0) begin
            chk("mem_addr", mem_addr, x_addr);
            chk("mem_we", 32'(mem_we), 32'(x_we));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(x_wstrb));
            if (x_we) chk("mem_wdata", mem_wdata, x_wdata);
        end
        chk("if_valid", 32'(if_valid), 32'(exp_ifv));
        chk("dm_valid", 32'(dm_valid), 32'(exp_dmv));
        if (exp_ifv) chk("if_rdata", if_rdata, exp_if_rdata);
        chk("dm_rdata", dm_rdata, exp_dm_rdata);
        chk("if_stall", 32'(if_stall), 32'(if_req && !exp_ifv));
        chk("dm_stall", 32'(dm_stall), 32'(dm_req && !exp_dmv));
        seen_ifv = if_valid;
        seen_dmv = dm_valid;
    endtask

    task automatic model_update();
        bit fin;
        bit decide;
        bit f_wait;
        bit d_wait;
        int win;
        fin    = (owner != 0) && mem_ready;
        decide = (owner == 0) || fin;
        f_wait = if_req && !exp_ifv && (owner != 1);
        d_wait = dm_req && !exp_dmv && (owner != 2);
        win = 0;
        if (decide) begin
            if (f_wait && d_wait) win = (streak == MAXS) ? 1 : 2;
            else if (f_wait)      win = 1;
            else if (d_wait)      win = 2;
        end
        exp_ifv = fin && (owner == 1) && !killed && !flush;
        exp_dmv = fin && (owner == 2);
        if (exp_ifv) exp_if_rdata = mem_rdata;
        if (exp_dmv && !x_we) exp_dm_rdata = mem_rdata;
        if (owner == 1) killed = fin ? 1'b0 : (killed || flush);
        if (win == 1 || !if_req) streak = 0;
        else if (win == 2 && streak < MAXS) streak++;
        if (decide) begin
            if (win == 1) begin
                x_addr = if_addr; x_we = 0; x_wdata = '0; x_wstrb = '0;
            end else if (win == 2) begin
                x_addr = dm_addr; x_we = dm_we; x_wdata = dm_wdata;
                x_wstrb = dm_we ? dm_wstrb : 4'b0000;
            end
            owner = win;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (rst_n) begin
            cycle_checks();
            model_update();
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_data();
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = $urandom() & 32'hFFFF_FFFC;
        dm_wdata = $urandom();
        dm_wstrb = 4'($urandom_range(1, 15));
    endtask

    initial begin
        model_reset();
        cyc();
        cyc();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_dm_valid", 32'(dm_valid), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Single fetch
        if_req = 1; if_addr = 32'h100;
        cyc();
        chk("f1_req", 32'(mem_req), 32'd1);
        chk("f1_addr", mem_addr, 32'h100);
        chk("f1_wstrb", 32'(mem_wstrb), 32'd0);
        cyc();
        mem_ready = 1; mem_rdata = 32'h0050_0093;
        cyc();
        mem_ready = 0;
        chk("f1_valid", 32'(if_valid), 32'd1);
        chk("f1_rdata", if_rdata, 32'h0050_0093);
        chk("f1_stall", 32'(if_stall), 32'd0);
        cyc();
        if_req = 0;
        chk("f1_pulse", 32'(if_valid), 32'd0);
        cyc();

        // Conflict: data first, fetch back-to-back
        if_req = 1; if_addr = 32'h300;
        dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
        cyc();
        chk("c_first_addr", mem_addr, 32'h2000);
        chk("c_first_we", 32'(mem_we), 32'd0);
        mem_ready = 1; mem_rdata = 32'hAAAA_5555;
        cyc();
        chk("c_b2b_req", 32'(mem_req), 32'd1);
        chk("c_b2b_addr", mem_addr, 32'h300);
        chk("c_dm_valid", 32'(dm_valid), 32'd1);
        chk("c_if_early", 32'(if_valid), 32'd0);
        chk("c_dm_rdata", dm_rdata, 32'hAAAA_5555);
        mem_rdata = 32'h1111_2222;
        cyc();
        dm_req = 0; mem_ready = 0;
        chk("c_if_valid", 32'(if_valid), 32'd1);
        chk("c_if_rdata", if_rdata, 32'h1111_2222);
        chk("c_dm_pulse", 32'(dm_valid), 32'd0);
        cyc();
        if_req = 0;
        cyc();

        // Stores under constant fetch pressure, fast memory
        if_req = 1; if_addr = 32'h400; mem_ready = 1;
        dm_req = 1; dm_we = 1; dm_addr = 32'h3000; dm_wdata = 32'h0BAD_F00D; dm_wstrb = 4'h5;
        st_done = 0;
        cyc();
        chk("st_we", 32'(mem_we), 32'd1);
        chk("st_addr", mem_addr, 32'h3000);
        chk("st_wdata", mem_wdata, 32'h0BAD_F00D);
        chk("st_wstrb", 32'(mem_wstrb), 32'h5);
        for (int i = 0; i < 80 && st_done < 6; i++) begin
            cyc();
            if (seen_dmv) begin
                st_done++;
                if (st_done < 6) begin
                    dm_addr  = 32'h3000 + 32'(4 * st_done);
                    dm_wdata = $urandom();
                    dm_wstrb = 4'($urandom_range(1, 15));
                end else begin
                    dm_req = 0;
                end
            end
            mem_rdata = $urandom();
        end
        chk("st_count", 32'(st_done), 32'd6);
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (seen_ifv) begin
                if_req = 0;
                break;
            end
        end
        mem_ready = 0;
        cyc();
        chk("st_drained", 32'(mem_req), 32'd0);

        // Flush kills an outstanding fetch
        if_req = 1; if_addr = 32'h40;
        cyc();
        chk("fl_addr", mem_addr, 32'h40);
        flush = 1; if_addr = 32'h80;
        cyc();
        flush = 0;
        cyc();
        cyc();
        mem_ready = 1; mem_rdata = 32'hBAD0_BAD0;
        cyc();
        mem_ready = 0;
        chk("fl_no_valid", 32'(if_valid), 32'd0);
        cyc();
        chk("fl_req2", 32'(mem_req), 32'd1);
        chk("fl_addr2", mem_addr, 32'h80);
        mem_ready = 1; mem_rdata = 32'h00A0_0113;
        cyc();
        mem_ready = 0;
        chk("fl_valid", 32'(if_valid), 32'd1);
        chk("fl_rdata", if_rdata, 32'h00A0_0113);
        cyc();
        if_req = 0;
        cyc();

        // Slow memory: request held stable for five wait cycles
        dm_req = 1; dm_we = 1; dm_addr = 32'h7000; dm_wdata = 32'hCAFE_F00D; dm_wstrb = 4'h3;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("sl_addr", mem_addr, 32'h7000);
            chk("sl_wdata", mem_wdata, 32'hCAFE_F00D);
            chk("sl_we", 32'(mem_we), 32'd1);
            chk("sl_stall", 32'(dm_stall), 32'd1);
            cyc();
        end
        mem_ready = 1;
        chk("sl_stall_last", 32'(dm_stall), 32'd1);
        cyc();
        mem_ready = 0;
        chk("sl_valid", 32'(dm_valid), 32'd1);
        chk("sl_stall_drop", 32'(dm_stall), 32'd0);
        chk("sl_rdata_held", dm_rdata, 32'hAAAA_5555);
        cyc();
        dm_req = 0;
        cyc();

        // Reset while a store is outstanding
        dm_req = 1; dm_we = 1; dm_addr = 32'h5000; dm_wdata = 32'h1234_5678; dm_wstrb = 4'hF;
        cyc();
        chk("rs_req_before", 32'(mem_req), 32'd1);
        mem_ready = 1; rst_n = 0;
        #1;
        chk("rs_req_now", 32'(mem_req), 32'd0);
        chk("rs_addr", mem_addr, 32'd0);
        chk("rs_dm_valid", 32'(dm_valid), 32'd0);
        dm_req = 0; if_req = 1; if_addr = 32'h600;
        cyc();
        mem_ready = 0; rst_n = 1;
        cyc();
        chk("rs_fetch_req", 32'(mem_req), 32'd1);
        chk("rs_fetch_addr", mem_addr, 32'h600);
        chk("rs_no_dm", 32'(dm_valid), 32'd0);
        mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        cyc();
        mem_ready = 0;
        chk("rs_if_valid", 32'(if_valid), 32'd1);
        chk("rs_if_rdata", if_rdata, 32'hDEAD_BEEF);
        cyc();
        if_req = 0;
        cyc();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (if_req) begin
                if (seen_ifv) begin
                    if_req  = 1'($urandom_range(0, 1));
                    if_addr = $urandom() & 32'hFFFF_FFFC;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req  = 1;
                if_addr = $urandom() & 32'hFFFF_FFFC;
            end
            flush = if_req && ($urandom_range(0, 7) == 0);
            if (flush) if_addr = $urandom() & 32'hFFFF_FFFC;
            if (dm_req) begin
                if (seen_dmv) begin
                    dm_req = 1'($urandom_range(0, 1));
                    new_data();
                end
            end else if ($urandom_range(0, 2) == 0) begin
                dm_req = 1;
                new_data();
            end
            mem_ready = ($urandom_range(0, 1) == 0);
            mem_rdata = $urandom();
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
